npc_ctrl_fsm: RTL and testbench

- Multi-cycle sequencer for the NPC core: steps fetch, decode, execute, memory and writeback around the combinational decoder, register file and ALU.
- Owns the instruction-memory and data-memory valid/ready handshakes, register-file write timing and PC update timing.
- Halts on ebreak, illegal instruction or memory timeout.
- Sits between the IFU/LSU memory ports and the decoder's one-hot instruction flags.

---
 rtl/npc_ctrl_pkg.sv | 16 +
 rtl/npc_ctrl_fsm_if.sv | 18 +
 rtl/npc_wait_timer.sv | 17 +
 rtl/npc_ctrl_fsm.sv | 103 ++++++++++
 tb/tb_npc_ctrl_fsm.sv | 134 +++++++++++++
 5 files changed

// File: rtl/npc_ctrl_pkg.sv
// npc_ctrl_pkg: shared state encodings and halt-reason codes for the NPC control sequencer
package npc_ctrl_pkg;
    typedef enum logic [2:0] {
        FETCH = 3'd0,
        IWAIT = 3'd1,
        EXEC  = 3'd2,
        MREQ  = 3'd3,
        MWAIT = 3'd4,
        WB    = 3'd5,
        HALT  = 3'd6
    } state_t;
    localparam logic [1:0] HALT_EBREAK  = 2'd0;
    localparam logic [1:0] HALT_ILLEGAL = 2'd1;
    localparam logic [1:0] HALT_ITO     = 2'd2;
    localparam logic [1:0] HALT_DTO     = 2'd3;
endpackage

// File: rtl/npc_ctrl_fsm_if.sv
// npc_ctrl_fsm_if: instruction- and data-memory valid/ready handshakes between sequencer and memories
interface npc_ctrl_fsm_if;
    logic imem_req_valid;
    logic imem_req_ready;
    logic imem_rsp_valid;
    logic dmem_req_valid;
    logic dmem_req_we;
    logic dmem_req_ready;
    logic dmem_rsp_valid;
    modport master (
        output imem_req_valid, dmem_req_valid, dmem_req_we,
        input  imem_req_ready, imem_rsp_valid, dmem_req_ready, dmem_rsp_valid
    );
    modport slave (
        input  imem_req_valid, dmem_req_valid, dmem_req_we,
        output imem_req_ready, imem_rsp_valid, dmem_req_ready, dmem_rsp_valid
    );
endinterface

// File: rtl/npc_wait_timer.sv
// npc_wait_timer: per-wait-state cycle counter; expired when the count reaches TIMEOUT (0 disables)
module npc_wait_timer #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    logic [TO_W-1:0] cnt;
    always_ff @(posedge clk)
        if (rst || clr) cnt <= '0;
        else if (en) cnt <= cnt + TO_W'(1);
    assign expired = (TIMEOUT != 0) && (cnt == TO_W'(TIMEOUT));
endmodule

// File: rtl/npc_ctrl_fsm.sv
// npc_ctrl_fsm: multi-cycle fetch/exec/mem/writeback sequencer with halt on ebreak, illegal or timeout.
// Define NPC_CTRL_PERF_EN to add the cyc_cnt/instret_cnt performance counters.
module npc_ctrl_fsm
    import npc_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           is_addi,
    input  logic           is_add,
    input  logic           is_jalr,
    input  logic           is_lui,
    input  logic           is_lw,
    input  logic           is_lbu,
    input  logic           is_sw,
    input  logic           is_sb,
    input  logic           is_ebreak,
    input  logic           dec_wen,
    npc_ctrl_fsm_if.master mem,
    output logic           inst_le,
    output logic           ld_le,
    output logic           rf_wen,
    output logic           pc_we,
    output logic           halted,
    output logic [1:0]     halt_code
`ifdef NPC_CTRL_PERF_EN
    ,
    output logic [63:0]    cyc_cnt,
    output logic [63:0]    instret_cnt
`endif
);
    state_t state, state_n;
    logic [1:0] code, code_n;
    logic run, is_st, is_mem, is_alu, wait_st, expired;
    assign run     = !rst;
    assign is_st   = is_sw | is_sb;
    assign is_mem  = is_lw | is_lbu | is_st;
    assign is_alu  = is_addi | is_add | is_jalr | is_lui;
    assign wait_st = state inside {FETCH, IWAIT, MREQ, MWAIT};
    always_ff @(posedge clk)
        if (rst) begin
            state <= FETCH;
            code  <= HALT_EBREAK;
        end else begin
            state <= state_n;
            code  <= code_n;
        end
    // handshakes are tested before the timeout so a completion on the last cycle wins
    always_comb begin
        state_n = state;
        code_n  = code;
        case (state)
            FETCH:
                if (mem.imem_req_ready) state_n = IWAIT;
                else if (expired) begin state_n = HALT; code_n = HALT_ITO; end
            IWAIT:
                if (mem.imem_rsp_valid) state_n = EXEC;
                else if (expired) begin state_n = HALT; code_n = HALT_ITO; end
            EXEC:
                if (is_ebreak) begin state_n = HALT; code_n = HALT_EBREAK; end
                else if (is_mem) state_n = MREQ;
                else if (is_alu) state_n = WB;
                else begin state_n = HALT; code_n = HALT_ILLEGAL; end
            MREQ:
                if (mem.dmem_req_ready) state_n = is_st ? WB : MWAIT;
                else if (expired) begin state_n = HALT; code_n = HALT_DTO; end
            MWAIT:
                if (mem.dmem_rsp_valid) state_n = WB;
                else if (expired) begin state_n = HALT; code_n = HALT_DTO; end
            WB:      state_n = FETCH;
            default: state_n = state;
        endcase
    end
    npc_wait_timer #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_n != state),
        .en      (wait_st),
        .expired (expired)
    );
    // outputs are forced low while rst is held, even before the state register settles
    assign mem.imem_req_valid = run && state == FETCH;
    assign mem.dmem_req_valid = run && state == MREQ;
    assign mem.dmem_req_we    = mem.dmem_req_valid && is_st;
    assign inst_le            = run && state == IWAIT && mem.imem_rsp_valid;
    assign ld_le              = run && state == MWAIT && mem.dmem_rsp_valid;
    assign pc_we              = run && state == WB;
    assign rf_wen             = pc_we && dec_wen && !is_st;
    assign halted             = run && state == HALT;
    assign halt_code          = run ? code : 2'd0;
`ifdef NPC_CTRL_PERF_EN
    always_ff @(posedge clk)
        if (rst) begin
            cyc_cnt     <= '0;
            instret_cnt <= '0;
        end else begin
            if (state != HALT) cyc_cnt <= cyc_cnt + 64'd1;
            if (pc_we || (state == EXEC && is_ebreak)) instret_cnt <= instret_cnt + 64'd1;
        end
`endif
endmodule

// File: tb/tb_npc_ctrl_fsm.sv
// tb_npc_ctrl_fsm: directed per-cycle vectors for npc_ctrl_fsm (TIMEOUT = 4) with hand-computed outputs
module tb_npc_ctrl_fsm;
    logic clk = 1'b0;
    logic rst;
    logic is_addi, is_add, is_jalr, is_lui, is_lw, is_lbu, is_sw, is_sb, is_ebreak;
    logic dec_wen, inst_le, ld_le, rf_wen, pc_we, halted;
    logic [1:0] halt_code;
    logic [9:0] obs;
    int n_cmp = 0;
    int n_err = 0;
    npc_ctrl_fsm_if mif ();
    npc_ctrl_fsm #(.TIMEOUT(4), .TO_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .is_addi   (is_addi),
        .is_add    (is_add),
        .is_jalr   (is_jalr),
        .is_lui    (is_lui),
        .is_lw     (is_lw),
        .is_lbu    (is_lbu),
        .is_sw     (is_sw),
        .is_sb     (is_sb),
        .is_ebreak (is_ebreak),
        .dec_wen   (dec_wen),
        .mem       (mif.master),
        .inst_le   (inst_le),
        .ld_le     (ld_le),
        .rf_wen    (rf_wen),
        .pc_we     (pc_we),
        .halted    (halted),
        .halt_code (halt_code)
    );
    always #5 clk = ~clk;
    // {imem_req_valid, inst_le, dmem_req_valid, dmem_req_we, ld_le, rf_wen, pc_we, halted, halt_code}
    assign obs = {mif.imem_req_valid, inst_le, mif.dmem_req_valid, mif.dmem_req_we,
                  ld_le, rf_wen, pc_we, halted, halt_code};
    localparam logic [8:0] OP_NONE = 9'h000, OP_ADDI = 9'h100, OP_LW = 9'h010,
                           OP_SB = 9'h002, OP_EBRK = 9'h001;
    localparam logic [9:0] O_IDLE = 10'b0000000000, O_FETCH = 10'b1000000000,
                           O_ILE = 10'b0100000000, O_LD = 10'b0010000000,
                           O_ST = 10'b0011000000, O_LLE = 10'b0000100000,
                           O_WB = 10'b0000011000, O_WBST = 10'b0000001000,
                           O_H0 = 10'b0000000100, O_H1 = 10'b0000000101,
                           O_H2 = 10'b0000000110, O_H3 = 10'b0000000111;
    // {rst, imem_req_ready, imem_rsp_valid, dmem_req_ready, dmem_rsp_valid}
    localparam logic [4:0] I_RST = 5'b1_0000, I_ZW = 5'b0_1100, I_DRDY = 5'b0_1110,
                           I_DRSP = 5'b0_1101, I_NONE = 5'b0_0000, I_ALL = 5'b0_1111;

    task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic op(input logic [8:0] f, input logic w);
        {is_addi, is_add, is_jalr, is_lui, is_lw, is_lbu, is_sw, is_sb, is_ebreak} = f;
        dec_wen = w;
    endtask

    task automatic vec(input string tag, input logic [4:0] in, input logic [9:0] exp);
        {rst, mif.imem_req_ready, mif.imem_rsp_valid, mif.dmem_req_ready, mif.dmem_rsp_valid} = in;
        #1;
        check(tag, obs, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch3(input string tag);
        vec({tag, "_fetch"}, I_ZW, O_FETCH);
        vec({tag, "_iwait"}, I_ZW, O_ILE);
        vec({tag, "_exec"}, I_ZW, O_IDLE);
    endtask

    initial begin
        op(OP_NONE, 1'b0);
        vec("rst0", I_RST, O_IDLE);
        vec("rst1", I_RST, O_IDLE);
        op(OP_ADDI, 1'b1);
        for (int i = 0; i < 3; i++) begin
            fetch3("addi");
            vec("addi_wb", I_ZW, O_WB);
        end
        op(OP_LW, 1'b1);
        fetch3("lw");
        vec("lw_mreq", I_DRDY, O_LD);
        repeat (3) vec("lw_mwait", I_ZW, O_IDLE);
        vec("lw_rsp", I_DRSP, O_LLE);
        vec("lw_wb", I_ZW, O_WB);
        op(OP_SB, 1'b1);
        fetch3("sb");
        repeat (2) vec("sb_mreq", I_ZW, O_ST);
        vec("sb_mreq_rdy", I_DRDY, O_ST);
        vec("sb_wb", I_ZW, O_WBST);
        op(OP_ADDI, 1'b1);
        repeat (4) vec("edge_fetch_wait", 5'b0_0100, O_FETCH);
        vec("edge_fetch_hs", I_ZW, O_FETCH);
        vec("edge_iwait_norsp", I_NONE, O_IDLE);
        vec("edge_iwait_rsp", 5'b0_0100, O_ILE);
        vec("edge_exec", I_ZW, O_IDLE);
        vec("edge_wb", I_ZW, O_WB);
        op(OP_EBRK, 1'b0);
        fetch3("ebrk");
        for (int i = 0; i < 100; i++) vec("ebrk_halt", I_ALL, O_H0);
        vec("ebrk_rst", I_RST, O_IDLE);
        op(OP_NONE, 1'b0);
        fetch3("ill");
        repeat (3) vec("ill_halt", I_ALL, O_H1);
        vec("ill_rst", I_RST, O_IDLE);
        op(OP_ADDI, 1'b1);
        repeat (5) vec("ito_wait", I_NONE, O_FETCH);
        vec("ito_halt", I_NONE, O_H2);
        vec("ito_hold", I_ALL, O_H2);
        vec("ito_rst", I_RST, O_IDLE);
        op(OP_LW, 1'b1);
        fetch3("dto");
        repeat (5) vec("dto_wait", I_ZW, O_LD);
        vec("dto_halt", I_ZW, O_H3);
        vec("dto_rst", I_RST, O_IDLE);
        fetch3("mw");
        vec("mw_mreq", I_DRDY, O_LD);
        vec("mw_wait", I_ZW, O_IDLE);
        vec("mw_rst", 5'b1_1111, O_IDLE);
        vec("mw_late_rsp", 5'b0_0001, O_FETCH);
        vec("mw_fetch", I_NONE, O_FETCH);
        vec("prio_rst", I_RST, O_IDLE);
        op(OP_EBRK | OP_LW, 1'b1);
        fetch3("prio");
        vec("prio_halt", I_ZW, O_H0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
